alu_issue_ctrl: RTL

Instruction issue and write-back controller that drives the `ALU` block. It accepts encoded instructions on a valid/ready stream and decodes them into `ALU` port activity: `CE`, `OP_CODE`, the two operands and `carry_in`. It captures `op_out`/`carry_out` into a 4-entry register file and a carry flag, and emits stored values on an output valid/ready stream. It sits between the fetch stage and the `ALU` in the Salamander-4 datapath.

---
 rtl/alu_issue_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/write-back controller for the ALU; ALU_ISSUE_CARRY_CHAIN_EN feeds the carry flag into ADD/SUB
module alu_issue_ctrl #(
  parameter int SIZE = 8,
  localparam int INSTR_W = SIZE + 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               alu_ce,
  output logic [3:0]         alu_op_code,
  output logic [SIZE-1:0]    alu_left,
  output logic [SIZE-1:0]    alu_right,
  output logic               alu_carry_in,
  input  logic [SIZE-1:0]    alu_op_out,
  input  logic               alu_carry_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SIZE-1:0]    out_data,
  output logic               carry_flag,
  output logic               illegal
);
  typedef enum logic [1:0] {IDLE, EXEC, WB, STORE} state_t;
  state_t                     state_q, state_d;
  logic [3:0][SIZE-1:0]       rf_q;
  logic                       carry_q, in_ready_q, alu_ce_q, out_valid_q, illegal_q;
  logic [3:0]                 alu_op_code_q, op_q;
  logic [SIZE-1:0]            alu_left_q, alu_right_q, out_data_q, imm_q;
  logic [1:0]                 dst_q;
  logic [3:0]                 opc;
  logic [1:0]                 dst, src;
  logic [SIZE-1:0]            imm;
  logic                       accept, reserved, is_ld, is_st, carry_op;
  assign opc      = in_instr[SIZE+7:SIZE+4];
  assign dst      = in_instr[SIZE+3:SIZE+2];
  assign src      = in_instr[SIZE+1:SIZE];
  assign imm      = in_instr[SIZE-1:0];
  assign accept   = in_valid && in_ready_q;
  assign reserved = opc >= 4'hC;
  assign is_ld    = opc == 4'h6;
  assign is_st    = opc == 4'h7;
  assign carry_op = op_q inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hA, 4'hB};
  // next-state decode: reserved opcodes are consumed without leaving IDLE
  always_comb begin
    state_d = state_q == IDLE  ? (!accept || reserved ? IDLE : is_ld ? WB : is_st ? STORE : EXEC) :
              state_q == EXEC  ? WB :
              state_q == WB    ? IDLE :
              out_ready        ? IDLE : STORE;
  end
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
  logic carry_in_q;
  // carry-in is only presented while ADD/SUB is executing
  always_ff @(posedge clk) begin
    if (rst) carry_in_q <= 1'b0;
    else carry_in_q <= accept && state_d == EXEC && opc <= 4'h1 && carry_q;
  end
  assign alu_carry_in = carry_in_q;
`else
  assign alu_carry_in = 1'b0;
`endif
  // FSM, register file and registered outputs; operands are captured at accept so they read pre-write-back values
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rf_q          <= '0;
      carry_q       <= 1'b0;
      in_ready_q    <= 1'b0;
      alu_ce_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      illegal_q     <= 1'b0;
      alu_op_code_q <= '0;
      alu_left_q    <= '0;
      alu_right_q   <= '0;
      out_data_q    <= '0;
      op_q          <= '0;
      dst_q         <= '0;
      imm_q         <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= state_d == IDLE;
      alu_ce_q    <= state_d == EXEC;
      out_valid_q <= state_d == STORE;
      illegal_q   <= accept && reserved;
      if (accept) begin
        op_q  <= opc;
        dst_q <= dst;
        imm_q <= imm;
      end
      if (accept && state_d == EXEC) begin
        alu_op_code_q <= opc;
        alu_left_q    <= rf_q[dst];
        alu_right_q   <= opc <= 4'h4 ? rf_q[src] : imm;
      end
      if (accept && is_st) out_data_q <= rf_q[src];
      if (state_q == WB) begin
        rf_q[dst_q] <= op_q == 4'h6 ? imm_q : alu_op_out;
        if (carry_op) carry_q <= alu_carry_out;
      end
    end
  end
  assign in_ready    = in_ready_q;
  assign alu_ce      = alu_ce_q;
  assign alu_op_code = alu_op_code_q;
  assign alu_left    = alu_left_q;
  assign alu_right   = alu_right_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign carry_flag  = carry_q;
  assign illegal     = illegal_q;
endmodule
